// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage pipeline.
// Turns hazard, branch and memory-wait events into per-stage enable, flush
// and bubble controls. Holds a memory-wait FSM with a timeout trap and
// saturating stall/flush performance counters.
module pipe_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_exe_en,
   output logic             id_exe_flush,
   output logic             exe_mem_en,
   output logic             mem_wb_bubble,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {StRun, StWait, StErr} state_t;

   state_t             state_q, state_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   flush_q, flush_d;
   logic               mem_stall;
   logic               in_err;

   assign mem_stall = mem_req & ~mem_ready;
   // During the reset cycle the outputs follow the RUN rules whatever the state.
   assign in_err    = (state_q == StErr) & ~rst;

   // Control outputs, highest priority first: trap, memory stall, branch, freeze.
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_en     = 1'b1;
      id_exe_flush  = 1'b0;
      exe_mem_en    = 1'b1;
      mem_wb_bubble = 1'b0;
      if (in_err || mem_stall) begin
         // Branch stays frozen in EXE and re-presents itself after the stall.
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_exe_en     = 1'b0;
         exe_mem_en    = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_exe_flush = 1'b1;
      end else if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_exe_flush = 1'b1;
      end
   end

   // Memory-wait FSM next state; completion wins over a same-cycle timeout.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               state_d = StWait;
               wait_d  = WaitW'(1);
            end else begin
               wait_d  = '0;
            end
         end
         StWait: begin
            if (!mem_stall) begin
               state_d = StRun;
               wait_d  = '0;
            end else if (wait_q == WaitLast) begin
               state_d = StErr;
               err_d   = 1'b1;
            end else begin
               wait_d  = wait_q + WaitW'(1);
            end
         end
         StErr: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = StRun;
            wait_d  = '0;
         end
      endcase
   end

   // Saturating performance counters; clear beats a same-cycle increment.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (clr_cnt) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (!pc_en && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
         if (if_id_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
      end
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         wait_q  <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign err       = err_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer of the hazard detector's freeze output and the SRAM controller's ready signal.
- Turns hazard, branch and memory-wait events into per-stage enable, flush and bubble controls for the 5-stage pipeline registers (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Sequential parts: a memory-wait state machine with a timeout/error trap, and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive memory-stall cycles before the ERR state is entered (must be >= 2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  load-use/RAW hazard from the hazard detector.
- branch_taken  input  1  branch resolved taken in EXE this cycle.
- mem_req  input  1  MEM stage holds an LDR/STR this cycle.
- mem_ready  input  1  SRAM controller completes the access this cycle.
- clr_cnt  input  1  synchronous clear of both performance counters.
- pc_en  output  1  PC register load enable.
- if_id_en  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clear to NOP.
- id_exe_en  output  1  ID/EXE load enable.
- id_exe_flush  output  1  ID/EXE control bits cleared (bubble).
- exe_mem_en  output  1  EXE/MEM load enable.
- mem_wb_bubble  output  1  MEM/WB loads with WB_EN/MEM_R cleared.
- err  output  1  sticky memory-timeout error.
- stall_cnt  output  CNT_W  cycles with any stall.
- flush_cnt  output  CNT_W  branch flushes taken.

Behaviour:
- Control outputs are combinational from the current state and inputs. State, wait counter, err and counters are registered.
- Reset values: state RUN, wait_cnt 0, err 0, stall_cnt 0, flush_cnt 0.
- Outputs during the reset cycle follow the RUN rules with the inputs present. rst has priority over all other updates.
- mem_stall = mem_req & ~mem_ready.
- States: RUN, WAIT, ERR.

Output priority, highest first:
- ERR: pc_en=if_id_en=id_exe_en=exe_mem_en=0, mem_wb_bubble=1, both flushes 0.
- mem_stall (RUN or WAIT): same outputs as ERR.
  - freeze and branch_taken are ignored. The branch instruction stays frozen in EXE, so branch_taken re-presents itself after the stall.
- branch_taken: all enables 1, if_id_flush=1, id_exe_flush=1, mem_wb_bubble=0. Branch overrides freeze.
- freeze: pc_en=0, if_id_en=0, id_exe_en=1, id_exe_flush=1, exe_mem_en=1, mem_wb_bubble=0.
- Otherwise: all enables 1, flushes 0, mem_wb_bubble 0.

State transitions:
- RUN: mem_stall -> WAIT, wait_cnt<=1. Else stay, wait_cnt<=0.
- WAIT: mem_ready or ~mem_req -> RUN, wait_cnt<=0.
- WAIT: mem_stall and wait_cnt==MEM_TIMEOUT-1 -> ERR, err<=1.
- WAIT: mem_stall otherwise -> stay, wait_cnt<=wait_cnt+1.
- ERR: absorbing; only rst leaves it. err stays 1.
- Net effect: ERR is entered after exactly MEM_TIMEOUT consecutive stall cycles.
- mem_ready arriving on the same cycle the timeout would fire: completion wins, return to RUN, err stays 0.

Counters:
- stall_cnt increments on any cycle where pc_en==0, including ERR.
- flush_cnt increments on any cycle where if_id_flush==1.
- Both saturate at 2^CNT_W-1; no wrap.
- clr_cnt zeroes both counters and has priority over a same-cycle increment.
- rst also zeroes them.

Test Plan:
- Reset then idle (all inputs 0) -> all enables 1, flushes 0, mem_wb_bubble 0, err 0, counters 0.
- freeze=1 for 2 cycles -> pc_en=if_id_en=0, id_exe_flush=1 both cycles; stall_cnt=2, flush_cnt=0.
- freeze=1 with branch_taken=1 in the same cycle -> pc_en=1, if_id_flush=id_exe_flush=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready low 3 cycles then high -> 3 cycles of all enables 0 and mem_wb_bubble=1; released on the ready cycle; stall_cnt=3, state back in RUN.
- MEM_TIMEOUT=4, mem_req=1 and mem_ready=0 held -> err=1 after the 4th stall cycle. Outputs stay frozen after mem_ready rises; err clears only on rst.
  - Repeat with mem_ready rising on the 4th cycle -> err stays 0.
- CNT_W=3, freeze held 10 cycles -> stall_cnt saturates at 7. clr_cnt=1 with freeze=1 -> stall_cnt=0 next cycle.
